// File: rtl/pcpu.sv
// pcpu: 5-stage (IF/ID/EX/MEM/WB) 16-bit CPU, one instruction per cycle, full operand forwarding.
// Latency: 5 cycles fetch to writeback; taken jumps/branches resolve in MEM and squash the younger slots; enable=0 freezes all state.
module pcpu (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    output logic [7:0]  i_addr,
    input  logic [15:0] i_datain,
    output logic [7:0]  d_addr,
    input  logic [15:0] d_datain,
    output logic [15:0] d_dataout,
    output logic        d_we,
    input  logic [3:0]  select_y,
    output logic [15:0] y
);
    localparam logic [4:0] OP_NOP  = 5'b00000, OP_HALT = 5'b00001, OP_LOAD = 5'b00010, OP_STORE = 5'b00011,
                           OP_SLL  = 5'b00100, OP_SRL  = 5'b00101, OP_SLA  = 5'b00110, OP_SRA   = 5'b00111,
                           OP_ADD  = 5'b01000, OP_ADDI = 5'b01001, OP_SUB  = 5'b01010, OP_SUBI  = 5'b01011,
                           OP_CMP  = 5'b01100, OP_AND  = 5'b01101, OP_OR   = 5'b01110, OP_XOR   = 5'b01111,
                           OP_LDIH = 5'b10000, OP_ADDC = 5'b10001, OP_SUBC = 5'b10100,
                           OP_JUMP = 5'b11000, OP_JMPR = 5'b11001, OP_BZ   = 5'b11010, OP_BNZ   = 5'b11011,
                           OP_BN   = 5'b11100, OP_BNN  = 5'b11101, OP_BC   = 5'b11110, OP_BNC   = 5'b11111;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t      state_q;
    logic [7:0]  pc_q;
    logic [15:0] id_ir_q, reg_A_q, reg_B_q, reg_C_q, reg_C1_q, sd_ex_q, sd_mem_q;
    logic [7:0]  ex_ctl_q, mem_ctl_q, wb_ctl_q;  // {op, r1} of the later stages
    logic [15:0] gr_q [8];
    logic        zf_q, nf_q, cf_q;

    logic [4:0]  id_op, ex_op, mem_op, wb_op;
    logic [2:0]  id_r1, id_r2, id_r3, ex_r1, mem_r1, wb_r1;
    logic [7:0]  id_imm;
    logic [3:0]  id_val3;
    logic [16:0] sum;
    logic [15:0] alu_res, op_a_d, op_b_d, sd_d;
    logic        upd_arith, upd_logic, taken, halting;

    assign id_op   = id_ir_q[15:11];
    assign id_r1   = id_ir_q[10:8];
    assign id_r2   = id_ir_q[6:4];
    assign id_r3   = id_ir_q[2:0];
    assign id_imm  = id_ir_q[7:0];
    assign id_val3 = id_ir_q[3:0];
    assign {ex_op, ex_r1}   = ex_ctl_q;
    assign {mem_op, mem_r1} = mem_ctl_q;
    assign {wb_op, wb_r1}   = wb_ctl_q;

    function automatic logic writes_reg(input logic [4:0] op);
        case (op)
            OP_LOAD, OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
            OP_AND, OP_OR, OP_XOR, OP_LDIH, OP_ADDC, OP_SUBC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // A load still in EX only has its address, hence the one-NOP load-use rule.
    function automatic logic [15:0] fwd(input logic [2:0] r);
        if (writes_reg(ex_op) && ex_op != OP_LOAD && ex_r1 == r) return alu_res;
        else if (writes_reg(mem_op) && mem_r1 == r) return (mem_op == OP_LOAD) ? d_datain : reg_C_q;
        else if (writes_reg(wb_op) && wb_r1 == r) return reg_C1_q;
        else return gr_q[r];
    endfunction

    always_comb begin
        op_a_d = '0;
        op_b_d = '0;
        sd_d   = '0;
        case (id_op)
            OP_ADDI, OP_SUBI: begin op_a_d = fwd(id_r1); op_b_d = {8'h00, id_imm}; end
            OP_LDIH:          begin op_a_d = fwd(id_r1); op_b_d = {id_imm, 8'h00}; end
            OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_LOAD:
                              begin op_a_d = fwd(id_r2); op_b_d = {12'h000, id_val3}; end
            OP_STORE:         begin op_a_d = fwd(id_r2); op_b_d = {12'h000, id_val3}; sd_d = fwd(id_r1); end
            OP_JUMP:          op_b_d = {8'h00, id_imm};
            OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
                              begin op_a_d = fwd(id_r1); op_b_d = {8'h00, id_imm}; end
            OP_ADD, OP_SUB, OP_ADDC, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR:
                              begin op_a_d = fwd(id_r2); op_b_d = fwd(id_r3); end
            default: ;
        endcase
    end

    always_comb begin
        upd_arith = 1'b0;
        upd_logic = 1'b0;
        case (ex_op)
            OP_ADD, OP_ADDI: begin sum = {1'b0, reg_A_q} + {1'b0, reg_B_q}; upd_arith = 1'b1; end
            OP_ADDC: begin sum = {1'b0, reg_A_q} + {1'b0, reg_B_q} + {16'h0000, cf_q}; upd_arith = 1'b1; end
            OP_SUB, OP_SUBI, OP_CMP: begin sum = {1'b0, reg_A_q} - {1'b0, reg_B_q}; upd_arith = 1'b1; end
            OP_SUBC: begin sum = {1'b0, reg_A_q} - {1'b0, reg_B_q} - {16'h0000, cf_q}; upd_arith = 1'b1; end
            OP_AND: begin sum = {1'b0, reg_A_q & reg_B_q}; upd_logic = 1'b1; end
            OP_OR:  begin sum = {1'b0, reg_A_q | reg_B_q}; upd_logic = 1'b1; end
            OP_XOR: begin sum = {1'b0, reg_A_q ^ reg_B_q}; upd_logic = 1'b1; end
            OP_SLL, OP_SLA: begin sum = {1'b0, reg_A_q << reg_B_q[3:0]}; upd_logic = 1'b1; end
            OP_SRL: begin sum = {1'b0, reg_A_q >> reg_B_q[3:0]}; upd_logic = 1'b1; end
            OP_SRA: begin sum = {1'b0, 16'($signed(reg_A_q) >>> reg_B_q[3:0])}; upd_logic = 1'b1; end
            default: sum = {1'b0, reg_A_q} + {1'b0, reg_B_q};  // LDIH, addresses, jump targets
        endcase
        alu_res = sum[15:0];
    end

    always_comb begin
        case (mem_op)
            OP_JUMP, OP_JMPR: taken = 1'b1;
            OP_BZ:  taken = zf_q;
            OP_BNZ: taken = ~zf_q;
            OP_BN:  taken = nf_q;
            OP_BNN: taken = ~nf_q;
            OP_BC:  taken = cf_q;
            OP_BNC: taken = ~cf_q;
            default: taken = 1'b0;
        endcase
    end

    assign halting   = (state_q == EXEC) && (ex_op == OP_HALT) && !taken;
    assign i_addr    = pc_q;
    assign d_addr    = reg_C_q[7:0];
    assign d_dataout = sd_mem_q;
    assign d_we      = enable && (mem_op == OP_STORE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q <= '0;      id_ir_q <= '0;   ex_ctl_q <= '0;  mem_ctl_q <= '0; wb_ctl_q <= '0;
            reg_A_q <= '0;   reg_B_q <= '0;   reg_C_q <= '0;   reg_C1_q <= '0;
            sd_ex_q <= '0;   sd_mem_q <= '0;  zf_q <= 1'b0;    nf_q <= 1'b0;    cf_q <= 1'b0;
            for (int i = 0; i < 8; i++) gr_q[i] <= '0;
        end else if (enable) begin
            if (writes_reg(wb_op)) gr_q[wb_r1] <= reg_C1_q;
            reg_C1_q  <= (mem_op == OP_LOAD) ? d_datain : reg_C_q;
            wb_ctl_q  <= mem_ctl_q;
            reg_C_q   <= alu_res;
            sd_mem_q  <= sd_ex_q;
            mem_ctl_q <= taken ? {OP_NOP, 3'd0} : ex_ctl_q;
            if (!taken && (upd_arith || upd_logic)) begin
                zf_q <= (alu_res == 16'h0000);
                nf_q <= alu_res[15];
                cf_q <= upd_arith ? sum[16] : 1'b0;
            end
            reg_A_q  <= op_a_d;
            reg_B_q  <= op_b_d;
            sd_ex_q  <= sd_d;
            ex_ctl_q <= (taken || halting) ? {OP_NOP, 3'd0} : {id_op, id_r1};
            if (taken) begin
                pc_q    <= reg_C_q[7:0];
                id_ir_q <= '0;
            end else if (state_q == EXEC && !halting) begin
                pc_q    <= pc_q + 8'd1;
                id_ir_q <= i_datain;
            end else begin
                id_ir_q <= '0;
            end
            case (state_q)
                IDLE: if (start) state_q <= EXEC;
                EXEC: if (halting) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (select_y)
            4'h8: y = {8'h00, pc_q};
            4'h9: y = id_ir_q;
            4'hA: y = reg_A_q;
            4'hB: y = reg_B_q;
            4'hC: y = reg_C_q;
            4'hD: y = reg_C1_q;
            4'hE: y = {13'h0000, zf_q, nf_q, cf_q};
            4'hF: y = 16'h0000;
            default: y = gr_q[select_y[2:0]];
        endcase
    end
endmodule

// File: tb/tb_pcpu.sv
// Directed bench for pcpu: forwarding chain, store, halt, branch squash, carry chain, enable freeze, async reset.
module tb_pcpu;
    logic        clock, reset, enable, start;
    logic [7:0]  i_addr, d_addr;
    logic [15:0] i_datain, d_datain, d_dataout, y;
    logic        d_we;
    logic [3:0]  select_y;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    int          total = 0, bad = 0;
    int          we_cnt = 0;
    logic [7:0]  we_addr = '0;
    logic [15:0] we_dat = '0;

    pcpu dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .i_addr(i_addr), .i_datain(i_datain),
        .d_addr(d_addr), .d_datain(d_datain), .d_dataout(d_dataout), .d_we(d_we),
        .select_y(select_y), .y(y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign i_datain = imem[i_addr];
    assign d_datain = dmem[d_addr];
    always @(posedge clock) if (d_we) dmem[d_addr] <= d_dataout;
    always @(negedge clock) if (d_we) begin
        we_cnt  = we_cnt + 1;
        we_addr = d_addr;
        we_dat  = d_dataout;
    end

    function automatic logic [15:0] rrr(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        return {op, a, 1'b0, b, 1'b0, c};
    endfunction
    function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] a, input logic [7:0] imm);
        return {op, a, imm};
    endfunction
    function automatic logic [15:0] rsh(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b, input logic [3:0] v);
        return {op, a, 1'b0, b, v};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chky(input string tag, input logic [3:0] sel, input logic [15:0] exp);
        @(negedge clock);
        select_y = sel;
        #1;
        chk(tag, y, exp);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; start = 1'b0; select_y = 4'h0;
        for (int i = 0; i < 256; i++) begin imem[i] = 16'h0000; dmem[i] = 16'h0000; end
        // program 1: preload, dependent ADD chain, store, halt
        imem[0]  = ri(5'b10000, 3'd1, 8'h07);
        imem[1]  = ri(5'b01001, 3'd1, 8'h55);
        imem[2]  = ri(5'b10000, 3'd2, 8'h6B);
        imem[3]  = ri(5'b01001, 3'd2, 8'h9C);
        imem[4]  = ri(5'b01001, 3'd3, 8'h01);
        imem[5]  = rrr(5'b01000, 3'd4, 3'd1, 3'd2);
        imem[6]  = rrr(5'b01000, 3'd5, 3'd4, 3'd3);
        imem[7]  = rrr(5'b01000, 3'd6, 3'd5, 3'd3);
        imem[8]  = rrr(5'b01000, 3'd7, 3'd6, 3'd3);
        imem[12] = rsh(5'b00011, 3'd7, 3'd0, 4'd3);
        imem[13] = 16'h0800;
        // program 2: jump away, CMP/BZ back to 0x10, borrow/carry chain
        imem[15] = ri(5'b11000, 3'd0, 8'h30);
        imem[16] = rrr(5'b01010, 3'd4, 3'd0, 3'd3);
        imem[17] = rrr(5'b10001, 3'd5, 3'd0, 3'd0);
        imem[18] = rrr(5'b01010, 3'd6, 3'd0, 3'd3);
        imem[19] = 16'h0800;
        imem[8'h30] = rrr(5'b01100, 3'd0, 3'd1, 3'd1);
        imem[8'h31] = ri(5'b11010, 3'd0, 8'h10);
        imem[8'h32] = ri(5'b01001, 3'd1, 8'h11);
        imem[8'h33] = ri(5'b01001, 3'd2, 8'h22);
        imem[8'h34] = ri(5'b01001, 3'd3, 8'h33);
        // program 3: increments (frozen mid-way), shifts, xor, load, halt
        imem[21] = ri(5'b01001, 3'd1, 8'h01);
        imem[22] = ri(5'b01001, 3'd1, 8'h01);
        imem[23] = ri(5'b01001, 3'd1, 8'h01);
        imem[24] = rsh(5'b00101, 3'd3, 3'd6, 4'd4);
        imem[25] = rsh(5'b00100, 3'd6, 3'd7, 4'd0);
        imem[26] = rrr(5'b01111, 3'd2, 3'd2, 3'd2);
        imem[27] = rsh(5'b00010, 3'd5, 3'd0, 4'd3);
        imem[28] = 16'h0800;

        #2;
        chk("rst_i_addr", {8'h00, i_addr}, 16'h0000);
        chk("rst_d_we", {15'h0000, d_we}, 16'h0000);
        chk("rst_d_addr", {8'h00, d_addr}, 16'h0000);
        chk("rst_d_dataout", d_dataout, 16'h0000);
        chky("rst_pc", 4'h8, 16'h0000);
        chky("rst_flags", 4'hE, 16'h0000);

        @(negedge clock);
        reset = 1'b1; enable = 1'b1;
        chky("idle_pc", 4'h8, 16'h0000);
        pulse_start();
        repeat (25) @(negedge clock);
        chky("p1_gr4", 4'h4, 16'h72F1);
        chky("p1_gr5", 4'h5, 16'h72F2);
        chky("p1_gr6", 4'h6, 16'h72F3);
        chky("p1_gr7", 4'h7, 16'h72F4);
        chk("store_cnt", 16'(we_cnt), 16'd1);
        chk("store_addr", {8'h00, we_addr}, 16'h0003);
        chk("store_data", we_dat, 16'h72F4);
        chk("dmem3", dmem[3], 16'h72F4);
        chky("halt_pc", 4'h8, 16'h000F);
        repeat (5) @(negedge clock);
        chky("halt_pc_hold", 4'h8, 16'h000F);
        chky("halt_gr1", 4'h1, 16'h0755);

        pulse_start();
        repeat (30) @(negedge clock);
        chky("br_gr1", 4'h1, 16'h0755);
        chky("br_gr2", 4'h2, 16'h6B9C);
        chky("br_gr3", 4'h3, 16'h0001);
        chky("sub_gr4", 4'h4, 16'hFFFF);
        chky("addc_gr5", 4'h5, 16'h0001);
        chky("sub_gr6", 4'h6, 16'hFFFF);
        chky("sub_flags", 4'hE, 16'h0003);
        chky("p2_pc", 4'h8, 16'h0015);

        pulse_start();
        @(negedge clock);
        @(negedge clock);
        enable = 1'b0;
        chky("frz_pc", 4'h8, 16'h0017);
        chky("frz_id_ir", 4'h9, 16'h4901);
        chky("frz_reg_A", 4'hA, 16'h0755);
        enable = 1'b1;
        repeat (30) @(negedge clock);
        chky("p3_gr1", 4'h1, 16'h0758);
        chky("p3_xor_gr2", 4'h2, 16'h0000);
        chky("p3_srl_gr3", 4'h3, 16'h0FFF);
        chky("p3_load_gr5", 4'h5, 16'h72F4);
        chky("p3_sll0_gr6", 4'h6, 16'h72F4);
        chky("p3_flags", 4'hE, 16'h0004);
        chky("p3_pc", 4'h8, 16'h001E);

        pulse_start();
        repeat (3) @(negedge clock);
        select_y = 4'h1;
        reset = 1'b0;
        #1;
        chk("arst_gr1", y, 16'h0000);
        chk("arst_i_addr", {8'h00, i_addr}, 16'h0000);
        select_y = 4'hE;
        #1;
        chk("arst_flags", y, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
